// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_pkg
// Description : Shared types and constants for the multicycle Hack CPU:
//               FSM state encoding, instruction field positions, jump codes
//               and default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

   // Default datapath widths
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 15;

   // Multicycle control states
   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      MREAD  = 2'd1,
      EXEC   = 2'd2,
      MWRITE = 2'd3
   } state_t;

   // C-instruction field positions (standard Hack layout)
   localparam int BIT_A    = 12;
   localparam int BIT_C_HI = 11;
   localparam int BIT_C_LO = 6;
   localparam int BIT_DST_A = 5;
   localparam int BIT_DST_D = 4;
   localparam int BIT_DST_M = 3;
   localparam int BIT_J_HI = 2;
   localparam int BIT_J_LO = 0;

   // Jump codes
   localparam logic [2:0] JNULL = 3'b000;
   localparam logic [2:0] JGT   = 3'b001;
   localparam logic [2:0] JEQ   = 3'b010;
   localparam logic [2:0] JGE   = 3'b011;
   localparam logic [2:0] JLT   = 3'b100;
   localparam logic [2:0] JNE   = 3'b101;
   localparam logic [2:0] JLE   = 3'b110;
   localparam logic [2:0] JMP   = 3'b111;

   // Evaluate a jump code against the ALU status flags
   function automatic logic jump_taken(input logic [2:0] j,
                                       input logic zr,
                                       input logic ng);
      logic taken;
      case (j)
         JGT:     taken = !zr && !ng;
         JEQ:     taken = zr;
         JGE:     taken = !ng;
         JLT:     taken = ng;
         JNE:     taken = !zr;
         JLE:     taken = zr || ng;
         JMP:     taken = 1'b1;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hack_alu_p.sv
`default_nettype none
// ============================================================================
// Module      : hack_alu_p
// Description : Purely combinational, width-parametrised Hack ALU.
//               Control bits zx/nx/zy/ny/f/no, status outputs zr/ng.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_alu_p #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_y,
   input  logic              i_zx,
   input  logic              i_nx,
   input  logic              i_zy,
   input  logic              i_ny,
   input  logic              i_f,
   input  logic              i_no,
   output logic [DATA_W-1:0] o_out,
   output logic              o_zr,
   output logic              o_ng
);

   logic [DATA_W-1:0] w_x_z;
   logic [DATA_W-1:0] w_x_n;
   logic [DATA_W-1:0] w_y_z;
   logic [DATA_W-1:0] w_y_n;
   logic [DATA_W-1:0] w_f;

   // Operand conditioning, function select and output negation
   always_comb begin
      w_x_z = i_zx ? '0 : i_x;
      w_x_n = i_nx ? ~w_x_z : w_x_z;
      w_y_z = i_zy ? '0 : i_y;
      w_y_n = i_ny ? ~w_y_z : w_y_z;
      w_f   = i_f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
      o_out = i_no ? ~w_f : w_f;
      o_zr  = (o_out == '0);
      o_ng  = o_out[DATA_W-1];
   end

endmodule
`default_nettype wire

// File: rtl/hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : hack_cpu_mc
// Description : Multicycle Hack CPU core. Fetches over a req/ack instruction
//               port and accesses M over a req/ack data port, so either
//               memory may insert any number of wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int              DATA_W   = DATA_W_DEF,
   parameter int              ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_d,
   output logic              retire
);

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_d;
   logic [DATA_W-1:0] r_m;
   logic [DATA_W-1:0] r_alu;
   logic              r_zr;
   logic              r_ng;

   logic              w_is_c;
   logic              w_sel_m;
   logic [5:0]        w_comp;
   logic              w_dst_a;
   logic              w_dst_d;
   logic              w_dst_m;
   logic [2:0]        w_jmp;

   logic [DATA_W-1:0] w_alu_y;
   logic [DATA_W-1:0] w_alu;
   logic              w_alu_zr;
   logic              w_alu_ng;

   logic [DATA_W-1:0] w_res;
   logic              w_res_zr;
   logic              w_res_ng;
   logic              w_jump;
   logic [ADDR_W-1:0] w_pc_inc;

   logic              w_imem_req;
   logic              w_dmem_req;
   logic              w_dmem_we;
   logic              w_commit;

   // Inline decode of the held instruction
   always_comb begin
      w_is_c  = r_ir[DATA_W-1];
      w_sel_m = r_ir[BIT_A];
      w_comp  = r_ir[BIT_C_HI:BIT_C_LO];
      w_dst_a = r_ir[BIT_DST_A];
      w_dst_d = r_ir[BIT_DST_D];
      w_dst_m = r_ir[BIT_DST_M];
      w_jmp   = r_ir[BIT_J_HI:BIT_J_LO];
      w_alu_y = w_sel_m ? r_m : r_a;
   end

   hack_alu_p #(
      .DATA_W (DATA_W)
   ) u_alu (
      .i_x   (r_d),
      .i_y   (w_alu_y),
      .i_zx  (w_comp[5]),
      .i_nx  (w_comp[4]),
      .i_zy  (w_comp[3]),
      .i_ny  (w_comp[2]),
      .i_f   (w_comp[1]),
      .i_no  (w_comp[0]),
      .o_out (w_alu),
      .o_zr  (w_alu_zr),
      .o_ng  (w_alu_ng)
   );

   // Commit operands: live ALU in EXEC, the EXEC snapshot once in MWRITE
   always_comb begin
      w_res    = (r_state == MWRITE) ? r_alu : w_alu;
      w_res_zr = (r_state == MWRITE) ? r_zr  : w_alu_zr;
      w_res_ng = (r_state == MWRITE) ? r_ng  : w_alu_ng;
      w_jump   = w_is_c && jump_taken(w_jmp, w_res_zr, w_res_ng);
      w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   end

   // Next-state and handshake/commit strobes
   always_comb begin
      w_state_nxt = r_state;
      w_imem_req  = 1'b0;
      w_dmem_req  = 1'b0;
      w_dmem_we   = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         FETCH: begin
            w_imem_req = 1'b1;
            if (imem_ack) begin
               w_state_nxt = (imem_rdata[DATA_W-1] && imem_rdata[BIT_A]) ? MREAD : EXEC;
            end
         end
         MREAD: begin
            w_dmem_req = 1'b1;
            if (dmem_ack) begin
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (w_is_c && w_dst_m) begin
               w_state_nxt = MWRITE;
            end else begin
               w_commit    = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         MWRITE: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = 1'b1;
            if (dmem_ack) begin
               w_commit    = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         default: w_state_nxt = FETCH;
      endcase
   end

   // Control state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Instruction register loads on fetch completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ir <= '0;
      end else if (r_state == FETCH && imem_ack) begin
         r_ir <= imem_rdata;
      end
   end

   // M operand latch on read completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m <= '0;
      end else if (r_state == MREAD && dmem_ack) begin
         r_m <= dmem_rdata;
      end
   end

   // Snapshot ALU result and flags so MWRITE sees a stable value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_alu <= '0;
         r_zr  <= 1'b0;
         r_ng  <= 1'b0;
      end else if (r_state == EXEC) begin
         r_alu <= w_alu;
         r_zr  <= w_alu_zr;
         r_ng  <= w_alu_ng;
      end
   end

   // Architectural commit: A, D and PC change together on the retire edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
         r_a  <= '0;
         r_d  <= '0;
      end else if (w_commit) begin
         if (!w_is_c) begin
            r_a <= {1'b0, r_ir[DATA_W-2:0]};
         end else begin
            if (w_dst_a) r_a <= w_res;
            if (w_dst_d) r_d <= w_res;
         end
         // Jump target is the A value from before this commit
         r_pc <= w_jump ? r_a[ADDR_W-1:0] : w_pc_inc;
      end
   end

   // Request/retire outputs are forced low while reset is held
   always_comb begin
      imem_req   = w_imem_req & reset;
      dmem_req   = w_dmem_req & reset;
      dmem_we    = w_dmem_we  & reset;
      retire     = w_commit   & reset;
      imem_addr  = r_pc;
      dmem_addr  = r_a[ADDR_W-1:0];
      dmem_wdata = r_alu;
      pc         = r_pc;
      reg_a      = r_a;
      reg_d      = r_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_cpu_mc
// Description : Self-checking bench for hack_cpu_mc: table-driven single
//               instruction vectors, directed multicycle sequences and a
//               random program run against an ISA-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_mc;

   localparam int DW = 16;
   localparam int AW = 15;
   localparam int MEMSZ = 32768;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [DW-1:0] imem_rdata = '0;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ack = 1'b0;
   logic [DW-1:0] dmem_rdata = '0;
   logic [AW-1:0] pc;
   logic [DW-1:0] reg_a;
   logic [DW-1:0] reg_d;
   logic          retire;

   hack_cpu_mc dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .pc         (pc),
      .reg_a      (reg_a),
      .reg_d      (reg_d),
      .retire     (retire)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] imem    [MEMSZ];
   logic [DW-1:0] dmem    [MEMSZ];
   logic [DW-1:0] ref_mem [MEMSZ];

   // Memory responder configuration: wait cycles per access, <0 = random 0..2
   int i_wait_cfg = 0;
   int d_wait_cfg = 0;
   int i_cnt = 0, i_w = 0, d_cnt = 0, d_w = 0;
   bit resp_on = 1'b1;

   // Data-port stability monitor state
   logic          mon_req = 1'b0;
   logic          mon_ack = 1'b0;
   logic          mon_we  = 1'b0;
   logic [AW-1:0] mon_addr = '0;
   logic [DW-1:0] mon_wdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int pick(input int cfg);
      return (cfg < 0) ? int'($urandom_range(2, 0)) : cfg;
   endfunction

   // Memory models and data-port hold monitor, all updated on the falling edge
   always @(negedge clk) begin
      if (reset && mon_req && !mon_ack && dmem_req) begin
         chk("dmem_hold", {dmem_we, dmem_addr, dmem_wdata}, {mon_we, mon_addr, mon_wdata});
      end
      mon_req   = dmem_req && reset;
      mon_ack   = dmem_ack;
      mon_we    = dmem_we;
      mon_addr  = dmem_addr;
      mon_wdata = dmem_wdata;
      if (resp_on) begin
         if (imem_req) begin
            if (i_cnt == 0) i_w = pick(i_wait_cfg);
            if (i_cnt >= i_w) begin
               imem_ack   = 1'b1;
               imem_rdata = imem[imem_addr];
            end else begin
               imem_ack = 1'b0;
            end
            i_cnt++;
         end else begin
            imem_ack = 1'b0;
            i_cnt    = 0;
         end
         if (dmem_req) begin
            if (d_cnt == 0) d_w = pick(d_wait_cfg);
            if (d_cnt >= d_w) begin
               dmem_ack = 1'b1;
               if (dmem_we) dmem[dmem_addr] = dmem_wdata;
               else         dmem_rdata = dmem[dmem_addr];
            end else begin
               dmem_ack = 1'b0;
            end
            d_cnt++;
         end else begin
            dmem_ack = 1'b0;
            d_cnt    = 0;
         end
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      i_cnt = 0;
      d_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   // Waits (bounded) for a retire pulse; cyc counts cycles including the retire one
   task automatic wait_retire(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         #1;
         cyc++;
         if (retire) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL retire_timeout: got no retire after %0d cycles, expected one", cyc);
      end
   endtask

   task automatic after_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mems();
      for (int k = 0; k < MEMSZ; k++) begin
         imem[k] = 16'hE000;
         dmem[k] = '0;
      end
   endtask

   // ---------------- ISA-level reference model ----------------
   logic [DW-1:0] mA, mD;
   logic [AW-1:0] mPC;
   logic [5:0]    comp_tab [18];

   function automatic logic [DW-1:0] hack_comp(input logic [5:0] c,
                                               input logic [DW-1:0] x,
                                               input logic [DW-1:0] y);
      case (c)
         6'b101010: return 16'd0;
         6'b111111: return 16'd1;
         6'b111010: return 16'hFFFF;
         6'b001100: return x;
         6'b110000: return y;
         6'b001101: return ~x;
         6'b110001: return ~y;
         6'b001111: return 16'd0 - x;
         6'b110011: return 16'd0 - y;
         6'b011111: return x + 16'd1;
         6'b110111: return y + 16'd1;
         6'b001110: return x - 16'd1;
         6'b110010: return y - 16'd1;
         6'b000010: return x + y;
         6'b010011: return x - y;
         6'b000111: return y - x;
         6'b000000: return x & y;
         6'b010101: return x | y;
         default:   return 16'hDEAD;
      endcase
   endfunction

   task automatic model_step();
      logic [DW-1:0] ins, y, res;
      logic          zr, ng, jmp;
      ins = imem[mPC];
      if (!ins[15]) begin
         mA  = {1'b0, ins[14:0]};
         mPC = mPC + 1'b1;
      end else begin
         y   = ins[12] ? ref_mem[mA[AW-1:0]] : mA;
         res = hack_comp(ins[11:6], mD, y);
         zr  = (res == 0);
         ng  = res[15];
         jmp = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !zr && !ng);
         if (ins[3]) ref_mem[mA[AW-1:0]] = res;
         mPC = jmp ? mA[AW-1:0] : mPC + 1'b1;
         if (ins[5]) mA = res;
         if (ins[4]) mD = res;
      end
   endtask

   function automatic logic [DW-1:0] gen_instr();
      if ($urandom_range(3, 0) == 0)
         return {1'b0, 15'($urandom)};
      return {3'b111, 1'($urandom), comp_tab[$urandom_range(17, 0)], 3'($urandom), 3'($urandom)};
   endfunction

   // ---------------- single-instruction vectors ----------------
   typedef struct {
      logic [15:0] instr;
      logic [14:0] dv;
      logic [14:0] av;
      logic [15:0] mem;
      int          dw;
      logic [15:0] ea;
      logic [15:0] ed;
      logic [14:0] epc;
      int          ecyc;
      bit          wr;
      logic [15:0] wval;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int  cyc, total, nret, diffs;
      bit  ok;

      comp_tab = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                   6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                   6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

      //           instr     D    A    M       dw  A'       D'       PC   cyc wr wval
      vecs[0]  = '{16'hE090, 7,   3,   16'h0,  0, 16'd3,   16'd10,  4,  2, 0, 16'd0};   // D=D+A
      vecs[1]  = '{16'hE7E8, 9,   100, 16'h0,  0, 16'd10,  16'd9,   4,  3, 1, 16'd10};  // AM=D+1
      vecs[2]  = '{16'hFC10, 0,   50,  16'h1234, 0, 16'd50, 16'h1234, 4, 3, 0, 16'd0};  // D=M
      vecs[3]  = '{16'hFC10, 0,   50,  16'h1234, 3, 16'd50, 16'h1234, 4, 6, 0, 16'd0};  // D=M, 3 waits
      vecs[4]  = '{16'hE302, 0,   20,  16'h0,  0, 16'd20,  16'd0,   20, 2, 0, 16'd0};   // D;JEQ taken
      vecs[5]  = '{16'hE302, 1,   20,  16'h0,  0, 16'd20,  16'd1,   4,  2, 0, 16'd0};   // D;JEQ not taken
      vecs[6]  = '{16'hFDC8, 5,   60,  16'd41, 0, 16'd60,  16'd5,   4,  4, 1, 16'd42};  // M=M+1
      vecs[7]  = '{16'hFDC8, 5,   60,  16'd41, 1, 16'd60,  16'd5,   4,  6, 1, 16'd42};  // M=M+1, 1 wait each
      vecs[8]  = '{16'hE4D4, 3,   8,   16'h0,  0, 16'd8,   16'hFFFB, 8, 2, 0, 16'd0};   // D=D-A;JLT
      vecs[9]  = '{16'hEA87, 0,   30,  16'h0,  0, 16'd30,  16'd0,   30, 2, 0, 16'd0};   // 0;JMP
      vecs[10] = '{16'hE000, 3,   5,   16'h0,  0, 16'd5,   16'd3,   4,  2, 0, 16'd0};   // NOP
      vecs[11] = '{16'h7FFF, 3,   5,   16'h0,  0, 16'h7FFF, 16'd3,  4,  2, 0, 16'd0};   // @32767
      vecs[12] = '{16'hE32F, 77,  40,  16'h0,  0, 16'd77,  16'd77,  40, 3, 1, 16'd77};  // AM=D;JMP

      // Reset state: outputs quiet while reset is held
      @(negedge clk);
      #1;
      chk("reset_reqs", {imem_req, dmem_req, dmem_we, retire}, 4'b0000);
      chk("reset_regs", {pc, reg_a, reg_d}, '0);

      // @7, D=A, @3, D=D+A with zero-wait memories
      clear_mems();
      imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0003; imem[3] = 16'hE090;
      i_wait_cfg = 0; d_wait_cfg = 0;
      do_reset();
      #1;
      chk("first_fetch", {imem_req, imem_addr}, {1'b1, 15'd0});
      total = 0; nret = 0;
      for (int k = 0; k < 4; k++) begin
         wait_retire(cyc, ok);
         if (!ok) break;
         total += cyc;
         nret++;
         if (k == 0) chk("a_instr_latency", cyc, 2);
         after_commit();
         if (k == 0) chk("a_instr_result", {reg_a, imem_addr}, {16'd7, 15'd1});
      end
      chk("seq_cycles", total, 8);
      chk("seq_retires", nret, 4);
      chk("seq_state", {reg_d, pc}, {16'd10, 15'd4});

      // Table: set D and A, then time and check one instruction
      foreach (vecs[v]) begin
         clear_mems();
         imem[0] = {1'b0, vecs[v].dv};
         imem[1] = 16'hEC10;
         imem[2] = {1'b0, vecs[v].av};
         imem[3] = vecs[v].instr;
         dmem[vecs[v].av] = vecs[v].mem;
         i_wait_cfg = 0;
         d_wait_cfg = vecs[v].dw;
         do_reset();
         ok = 1'b1;
         for (int k = 0; k < 3 && ok; k++) begin
            wait_retire(cyc, ok);
            if (ok) after_commit();
         end
         if (!ok) continue;
         wait_retire(cyc, ok);
         if (!ok) continue;
         chk($sformatf("vec%0d_cycles", v), cyc, vecs[v].ecyc);
         if (vecs[v].wr) begin
            chk($sformatf("vec%0d_write", v), {dmem_req, dmem_we, dmem_addr, dmem_wdata, reg_a},
                {1'b1, 1'b1, vecs[v].av, vecs[v].wval, 1'b0, vecs[v].av});
         end
         after_commit();
         chk($sformatf("vec%0d_regs", v), {reg_a, reg_d, pc}, {vecs[v].ea, vecs[v].ed, vecs[v].epc});
         if (vecs[v].wr) chk($sformatf("vec%0d_mem", v), dmem[vecs[v].av], vecs[v].wval);
      end

      // PC wrap: jump to 32767, then a non-jumping instruction there
      clear_mems();
      imem[0] = 16'h7FFF; imem[1] = 16'hEA87; imem[15'h7FFF] = 16'h0005;
      i_wait_cfg = 1; d_wait_cfg = 0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         wait_retire(cyc, ok);
         if (!ok) break;
         after_commit();
         if (k == 1) chk("jump_top", pc, 15'h7FFF);
      end
      chk("pc_wrap", {pc, reg_a}, {15'd0, 16'd5});

      // Reset during an MWRITE wait abandons the access; a stray ack is ignored
      clear_mems();
      imem[0] = 16'h0064; imem[1] = 16'hE308;
      i_wait_cfg = 0; d_wait_cfg = 20;
      do_reset();
      wait_retire(cyc, ok);
      after_commit();
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         if (dmem_req) begin ok = 1'b1; break; end
      end
      chk("mwrite_started", {ok, dmem_we, dmem_addr}, {1'b1, 1'b1, 15'd100});
      @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk("async_reset_reqs", {imem_req, dmem_req, dmem_we, retire}, 4'b0000);
      chk("async_reset_regs", {pc, reg_a, reg_d}, '0);
      resp_on = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      dmem_ack = 1'b1;
      dmem_rdata = 16'hBEEF;
      nret = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         if (retire || dmem_req) nret++;
      end
      chk("stray_ack_ignored", {nret, pc, reg_a, reg_d}, {32'd0, 15'd0, 16'd0, 16'd0});
      dmem_ack = 1'b0;
      i_cnt = 0; d_cnt = 0;
      resp_on = 1'b1;
      wait_retire(cyc, ok);
      after_commit();
      chk("recover_after_reset", {reg_a, pc}, {16'd100, 15'd1});

      // Random program with random wait states against the reference model
      for (int k = 0; k < MEMSZ; k++) begin
         imem[k]    = gen_instr();
         dmem[k]    = 16'($urandom);
         ref_mem[k] = dmem[k];
      end
      mA = '0; mD = '0; mPC = '0;
      i_wait_cfg = -1; d_wait_cfg = -1;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         wait_retire(cyc, ok);
         if (!ok) break;
         model_step();
         after_commit();
         chk($sformatf("rand%0d_pc_a_d", n), {pc, reg_a, reg_d}, {mPC, mA, mD});
      end
      diffs = 0;
      for (int k = 0; k < MEMSZ; k++) if (dmem[k] !== ref_mem[k]) diffs++;
      chk("rand_mem_diffs", diffs, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
